// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-store write port of the boot loader.
// slave = loader side, master = host / instruction-store side.
interface imem_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output in_valid, in_data, input in_ready, wr_en, wr_addr, wr_data);
   modport slave  (input in_valid, in_data, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs a length-prefixed byte stream MSB-first into the instruction store,
// zero-fills the rest and holds the CPU until done. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   imem_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            done,
   output logic            err,
   output logic [ADDR_W:0] word_count
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int BPW   = DATA_W / 8;
   localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_FILL, S_DONE, S_ERR, S_CHK
   } state_t;

   state_t            state;
   logic [ADDR_W:0]   n_len;
   logic [ADDR_W-1:0] addr;
   logic [BC_W-1:0]   byte_cnt;
   logic [DATA_W-1:0] asm_word;
   logic [DATA_W-1:0] next_word;
   logic              xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign xfer      = bus.in_valid && bus.in_ready;
   assign next_word = (asm_word << 8) | DATA_W'(bus.in_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         n_len       <= '0;
         addr        <= '0;
         byte_cnt    <= '0;
         asm_word    <= '0;
         bus.in_ready <= 1'b0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         word_count  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else if (start) begin
         // start from any state restarts the load; words already written stay in the store
         state        <= S_LEN;
         bus.in_ready <= 1'b1;
         bus.wr_en    <= 1'b0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         word_count   <= '0;
         byte_cnt     <= '0;
         addr         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         case (state)
            S_LEN: if (xfer) begin
               if (bus.in_data == 8'd0 || int'(bus.in_data) > DEPTH) begin
                  state        <= S_ERR;
                  bus.in_ready <= 1'b0;
                  err          <= 1'b1;
               end else begin
                  n_len <= (ADDR_W+1)'(bus.in_data);
                  state <= S_DATA;
               end
            end
            S_DATA: if (xfer) begin
               asm_word <= next_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum     <= csum ^ bus.in_data;
`endif
               if (byte_cnt == BC_W'(BPW-1)) begin
                  byte_cnt     <= '0;
                  state        <= S_WRITE;
                  bus.in_ready <= 1'b0;
                  bus.wr_en    <= 1'b1;
                  bus.wr_addr  <= addr;
                  bus.wr_data  <= next_word;
                  word_count   <= word_count + 1'b1;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               bus.wr_en <= 1'b0;
               if (word_count == n_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state        <= S_CHK;
                  bus.in_ready <= 1'b1;
`else
                  if (n_len == (ADDR_W+1)'(DEPTH)) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state       <= S_FILL;
                     bus.wr_en   <= 1'b1;
                     bus.wr_addr <= n_len[ADDR_W-1:0];
                     bus.wr_data <= '0;
                  end
`endif
               end else begin
                  addr         <= addr + 1'b1;
                  state        <= S_DATA;
                  bus.in_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (xfer) begin
               bus.in_ready <= 1'b0;
               if (bus.in_data != csum) begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end else if (n_len == (ADDR_W+1)'(DEPTH)) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  state       <= S_FILL;
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= n_len[ADDR_W-1:0];
                  bus.wr_data <= '0;
               end
            end
`endif
            S_FILL: begin
               // one zero (NOP) write per cycle up to the top of the store
               if (bus.wr_addr == ADDR_W'(DEPTH-1)) begin
                  bus.wr_en <= 1'b0;
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cpu_hold  <= 1'b0;
               end else begin
                  bus.wr_addr <= bus.wr_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected store writes are queued per load, a monitor pops them.
module tb_imem_loader;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BPW    = DATA_W / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, done, err;
   logic [ADDR_W:0] word_count;

   imem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; } wr_t;
   wr_t        exp_q[$];
   logic [7:0] dq[$];
   int         tests = 0;
   int         fails = 0;
   int         stalls;

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // monitor: every store write must match the head of the expectation queue
   always @(negedge clk) begin
      if (!rst && bus.wr_en) begin
         chk("ready_low_in_write", int'(bus.in_ready), 0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", bus.wr_addr, bus.wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", int'(bus.wr_addr), e.addr);
            chk("wr_data", int'(bus.wr_data), e.data);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // drive one byte and wait until it has been accepted; called at a negedge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && w < 100) begin
         stalls++;
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: byte 0x%0h never accepted", b);
      end
      @(negedge clk);
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_end();
      int w;
      w = 0;
      while (!(done || err) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         tests++;
         fails++;
         $display("FAIL end_timeout: neither done nor err");
      end
   endtask

   function automatic int pick_gap(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(0, 2));
   endfunction

   // full load of dq (n words); expected writes come from the word/fill rule directly
   task automatic run_load(input int n, input int gap_mode);
      logic [7:0] x;
      int w;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = 0;
         for (int b = 0; b < BPW; b++) w = (w << 8) | int'(dq[i*BPW+b]);
         exp_q.push_back('{i, w});
      end
      for (int a = n; a < DEPTH; a++) exp_q.push_back('{a, 0});
      foreach (dq[k]) x ^= dq[k];
      pulse_start();
      chk("wc_clear_on_start", int'(word_count), 0);
      chk("hold_on_start", int'(cpu_hold), 1);
      stalls = 0;
      send_byte(8'(n), pick_gap(gap_mode));
      foreach (dq[k]) send_byte(dq[k], pick_gap(gap_mode));
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x, 0);
`endif
      bus.in_valid = 1'b0;
      wait_end();
      @(negedge clk);
      chk("done", int'(done), 1);
      chk("err", int'(err), 0);
      chk("cpu_hold_released", int'(cpu_hold), 0);
      chk("word_count", int'(word_count), n);
      chk("writes_outstanding", exp_q.size(), 0);
   endtask

   task automatic run_bad_len(input logic [7:0] len);
      pulse_start();
      send_byte(len, 0);
      bus.in_valid = 1'b0;
      wait_end();
      repeat (3) @(negedge clk);
      chk("bad_len_err", int'(err), 1);
      chk("bad_len_done", int'(done), 0);
      chk("bad_len_hold", int'(cpu_hold), 1);
      chk("bad_len_ready", int'(bus.in_ready), 0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #12;
      chk("rst_hold", int'(cpu_hold), 1);
      chk("rst_ready", int'(bus.in_ready), 0);
      chk("rst_wr_en", int'(bus.wr_en), 0);
      chk("rst_wr_addr", int'(bus.wr_addr), 0);
      chk("rst_wr_data", int'(bus.wr_data), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_wc", int'(word_count), 0);
      @(negedge clk) rst = 1'b0;

      // asynchronous reset in the middle of DATA
      pulse_start();
      send_byte(8'h03, 0);
      send_byte(8'h81, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_hold", int'(cpu_hold), 1);
      chk("arst_ready", int'(bus.in_ready), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_wc", int'(word_count), 0);
      bus.in_valid = 1'b0;
      @(negedge clk) rst = 1'b0;

      // three words streamed back to back
      dq = '{8'h81, 8'h80, 8'h2C, 8'hB2, 8'hDC, 8'h67};
      run_load(3, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("write_bubbles", stalls, 3);
`else
      chk("write_bubbles", stalls, 2);
`endif

      // bad lengths, then recovery
      run_bad_len(8'h00);
      run_bad_len(8'h09);
      dq = '{8'hA5, 8'h5A};
      run_load(1, 0);

      // full store, no fill, host stalling every other cycle
      dq.delete();
      for (int i = 0; i < 2*DEPTH; i++) dq.push_back(8'(8'h10 + i*7));
      run_load(DEPTH, 1);

      // restart after one word written
      exp_q.push_back('{0, 16'h1122});
      pulse_start();
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_wc_mid", int'(word_count), 1);
      chk("abort_queue", exp_q.size(), 0);
      dq = '{8'h12, 8'h34};
      run_load(1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_q.push_back('{0, 16'h1234});
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h27, 0);
      bus.in_valid = 1'b0;
      wait_end();
      repeat (3) @(negedge clk);
      chk("bad_csum_err", int'(err), 1);
      chk("bad_csum_hold", int'(cpu_hold), 1);
      chk("bad_csum_writes", exp_q.size(), 0);
`endif

      // randomized loads with random host stalls
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, DEPTH));
         dq.delete();
         for (int i = 0; i < n*BPW; i++) dq.push_back(8'($urandom_range(0, 255)));
         run_load(n, 2);
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader and the write side of the instruction memory.
- Accepts a byte stream from a host over a valid/ready handshake and packs bytes MSB-first into DATA_W-bit instruction words.
- Writes each word into the writable instruction store, zero-fills the unused words (zero = NOP) and holds the CPU until loading completes.

Parameters:
DATA_W, 16, instruction width in bits; multiple of 8
ADDR_W, 3, word address width; store depth = 2**ADDR_W words

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins (or restarts) a load
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction store write strobe
wr_addr  output  ADDR_W  store word address
wr_data  output  DATA_W  store write data
cpu_hold  output  1  holds CPU (PC) in reset while high
done  output  1  load completed successfully
err  output  1  load aborted on bad length (or checksum)
word_count  output  ADDR_W+1  words written from the stream in the last/current load

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, word_count=0, cpu_hold=1.
- Byte transfer: occurs only when in_valid && in_ready, sampled on the rising clk edge.
- All outputs are registered.
- States:
  - IDLE: in_ready=0. On start -> LEN; clear done, err, word_count and the byte counter; cpu_hold=1.
  - LEN: in_ready=1. The accepted byte is N, the word count.
    - N==0 or N>2**ADDR_W -> ERR.
    - Otherwise latch N -> DATA.
  - DATA: in_ready=1. Shift each accepted byte into the low byte of the assembly register; the first byte ends up as the MSB.
    - After DATA_W/8 bytes -> WRITE.
  - WRITE (1 cycle): in_ready=0.
    - wr_en=1, wr_addr=current address, wr_data=assembled word; word_count increments.
    - If word_count reaches N -> FILL (or CHK when the optional checksum is compiled in).
    - Otherwise address+1 -> DATA.
  - FILL: in_ready=0. wr_en=1 with wr_data=0 for each address N..2**ADDR_W-1, one per cycle.
    - Skipped when N==2**ADDR_W.
    - After the last address -> DONE.
  - DONE: done=1, cpu_hold=0, wr_en=0. start -> LEN (reload; cpu_hold returns to 1 the next cycle).
  - ERR: err=1, cpu_hold=1, in_ready=0. start -> LEN.
- Latency:
  - Last byte of a word accepted at edge k -> wr_en high during cycle k+1.
  - Minimum byte period is one cycle, except the bubble in the WRITE cycle.
- start in LEN/DATA/WRITE/FILL: abort and restart at LEN. Partially written words remain in the store; word_count clears.
- Host stalls (in_valid=0): the state machine waits indefinitely; no timeout.
- The address counter never wraps: N is bounded by the LEN check.
- Reset mid-load: immediate return to reset values; store contents undefined to the CPU because cpu_hold=1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the final WRITE, state CHK accepts one extra byte.
  - Expected value = XOR of all data bytes (the length byte is excluded).
  - Match -> FILL; mismatch -> ERR.
- Undefined: no CHK state; WRITE of the final word goes directly to FILL.

Test Plan:
- Reset during DATA with rst pulse mid-cycle -> outputs asynchronously at reset values: cpu_hold=1, in_ready=0, done=0, err=0.
- start; bytes 03, 81,80, 2C,B2, DC,67 streamed with in_valid held high -> writes (0,0x8180), (1,0x2CB2), (2,0xDC67), then zero writes at addr 3..7. Also require: done=1, cpu_hold=0, word_count=3; in_ready low exactly in the WRITE cycles.
- start; length byte 00, then separately length 09 -> err=1, no wr_en pulses, cpu_hold=1; a following start with valid stream recovers to done.
- Length 08 with 16 data bytes, in_valid toggled every other cycle -> 8 writes, addr 0..7, no FILL writes, done=1; byte order preserved under stalls.
- start mid-stream after 1 word written, then new stream 01, 12,34 -> word_count restarts; write (0,0x1234) followed by zero fill 1..7, done=1.
- With IMEM_LOADER_CHECKSUM_EN: stream 01, 12,34, checksum 26 -> done=1; checksum 27 -> err=1, no FILL writes.
